one_wire_bus_master: RTL and testbench

//  Downstream of the 1-wire data controller: takes its one-cycle `write` start pulse and latched command fields, and runs the full bus transaction.

---
 rtl/one_wire_bus_master_if.sv | 42 ++++
 rtl/one_wire_bus_master.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_one_wire_bus_master.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/one_wire_bus_master_if.sv
// Command, BRAM, receive-buffer and line signals of the 1-wire bus master.
// ow_spu exists only when OW_STRONG_PULLUP_EN is defined.
interface one_wire_bus_master_if;
   logic        write;
   logic [2:0]  read_command;
   logic [7:0]  ROM_command;
   logic [7:0]  Fun_cmd;
   logic [3:0]  data_length;
   logic        read_write;
   logic [55:0] UID_Data;
   logic [7:0]  uid_crc;
   logic [4:0]  bram_raddr;
   logic [7:0]  bram_rdata;
   logic [7:0]  rx_data;
   logic [4:0]  rx_addr;
   logic        rx_we;
   logic        ow_drive_low;
   logic        ow_in;
   logic        ow_busy;
   logic        presence_err;
`ifdef OW_STRONG_PULLUP_EN
   logic        ow_spu;
`endif

   modport master (
      input  write, read_command, ROM_command, Fun_cmd, data_length, read_write,
      input  UID_Data, uid_crc, bram_rdata, ow_in,
      output bram_raddr, rx_data, rx_addr, rx_we, ow_drive_low, ow_busy, presence_err
`ifdef OW_STRONG_PULLUP_EN
      , output ow_spu
`endif
   );

   modport slave (
      output write, read_command, ROM_command, Fun_cmd, data_length, read_write,
      output UID_Data, uid_crc, bram_rdata, ow_in,
      input  bram_raddr, rx_data, rx_addr, rx_we, ow_drive_low, ow_busy, presence_err
`ifdef OW_STRONG_PULLUP_EN
      , input ow_spu
`endif
   );
endinterface

// File: rtl/one_wire_bus_master.sv
// 1-wire bus master: reset/presence, ROM/UID/CRC/function bytes, then BRAM writes or bus reads.
// Define OW_STRONG_PULLUP_EN to add the ow_spu strong pull-up hold after write transactions.
module one_wire_bus_master #(
   parameter int CLKS_PER_US = 50,
   parameter int T_RSTL_US   = 480,
   parameter int T_PDS_US    = 70,
   parameter int T_LOW1_US   = 6,
   parameter int T_LOW0_US   = 60,
   parameter int T_RDS_US    = 15,
   parameter int T_SLOT_US   = 65,
   parameter int T_SPU_US    = 10
) (
   input logic                   clk,
   input logic                   rst,
   one_wire_bus_master_if.master bus
);
   localparam logic [15:0] RSTL_C = 16'(T_RSTL_US * CLKS_PER_US);
   localparam logic [15:0] PDS_C  = 16'(T_PDS_US  * CLKS_PER_US);
   localparam logic [15:0] LOW1_C = 16'(T_LOW1_US * CLKS_PER_US);
   localparam logic [15:0] LOW0_C = 16'(T_LOW0_US * CLKS_PER_US);
   localparam logic [15:0] RDS_C  = 16'(T_RDS_US  * CLKS_PER_US);
   localparam logic [15:0] SLOT_C = 16'(T_SLOT_US * CLKS_PER_US);
   localparam logic [15:0] SPU_C  = 16'(T_SPU_US  * CLKS_PER_US);

   typedef enum logic [2:0] {IDLE, RST_LOW, RST_WAIT, LOAD, SLOT_LOW, SLOT_REL, NEXT, SPU} state_t;
   typedef enum logic [2:0] {PH_ROM, PH_UID, PH_CRC, PH_FUNC, PH_DATA} phase_t;

   state_t      state, state_nxt;
   phase_t      phase, phase_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [4:0]  byte_idx, byte_idx_nxt;
   logic [4:0]  data_idx, data_idx_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  sr, sr_nxt;
   logic        rbit, rbit_nxt;
   logic [2:0]  rc, rc_nxt;
   logic [7:0]  rom, rom_nxt;
   logic [7:0]  fun, fun_nxt;
   logic [3:0]  dlen, dlen_nxt;
   logic        rw, rw_nxt;
   logic [55:0] uid, uid_nxt;
   logic [7:0]  crc, crc_nxt;
   logic [7:0]  rx_data, rx_data_nxt;
   logic [4:0]  rx_addr, rx_addr_nxt;
   logic        rx_we, rx_we_nxt;
   logic        drive, drive_nxt;
   logic        busy, busy_nxt;
   logic        perr, perr_nxt;
   logic        is_read;
   logic        last_byte;
   logic [7:0]  load_byte;
   logic [15:0] low_c;

   assign is_read = (phase == PH_DATA) && !rw;
   assign low_c   = (is_read || sr[0]) ? LOW1_C : LOW0_C;

`ifdef OW_STRONG_PULLUP_EN
   logic spu, spu_nxt;
   logic spu_wanted;
   assign spu_wanted = rw || !((rc == 3'd0) || (rc == 3'd2));
   assign bus.ow_spu = spu;
`endif

   always_comb begin
      load_byte = rom;
      case (phase)
         PH_ROM:  load_byte = rom;
         PH_UID: begin
            case (byte_idx[2:0])
               3'd0:    load_byte = uid[7:0];
               3'd1:    load_byte = uid[15:8];
               3'd2:    load_byte = uid[23:16];
               3'd3:    load_byte = uid[31:24];
               3'd4:    load_byte = uid[39:32];
               3'd5:    load_byte = uid[47:40];
               default: load_byte = uid[55:48];
            endcase
         end
         PH_CRC:  load_byte = crc;
         PH_FUNC: load_byte = fun;
         default: load_byte = bus.bram_rdata;
      endcase
   end

   // Slot timing: one counter runs from the start of each slot so low time, sample point and slot end share it.
   always_comb begin
      state_nxt    = state;
      phase_nxt    = phase;
      cnt_nxt      = cnt;
      byte_idx_nxt = byte_idx;
      data_idx_nxt = data_idx;
      bit_cnt_nxt  = bit_cnt;
      sr_nxt       = sr;
      rbit_nxt     = rbit;
      rc_nxt       = rc;
      rom_nxt      = rom;
      fun_nxt      = fun;
      dlen_nxt     = dlen;
      rw_nxt       = rw;
      uid_nxt      = uid;
      crc_nxt      = crc;
      rx_data_nxt  = rx_data;
      rx_addr_nxt  = rx_addr;
      rx_we_nxt    = 1'b0;
      busy_nxt     = busy;
      perr_nxt     = perr;
      last_byte    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.write) begin
               rc_nxt       = bus.read_command;
               rom_nxt      = bus.ROM_command;
               fun_nxt      = bus.Fun_cmd;
               dlen_nxt     = bus.data_length;
               rw_nxt       = bus.read_write;
               uid_nxt      = bus.UID_Data;
               crc_nxt      = bus.uid_crc;
               phase_nxt    = PH_ROM;
               byte_idx_nxt = '0;
               data_idx_nxt = '0;
               bit_cnt_nxt  = '0;
               cnt_nxt      = '0;
               perr_nxt     = 1'b0;
               busy_nxt     = 1'b1;
               state_nxt    = RST_LOW;
            end
         end
         RST_LOW: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt >= RSTL_C - 16'd1) begin
               cnt_nxt   = '0;
               state_nxt = RST_WAIT;
            end
         end
         RST_WAIT: begin
            cnt_nxt = cnt + 16'd1;
            if ((cnt == PDS_C) && bus.ow_in)
               perr_nxt = 1'b1;
            if (cnt >= RSTL_C - 16'd1) begin
               cnt_nxt   = '0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            sr_nxt      = is_read ? 8'h00 : load_byte;
            bit_cnt_nxt = '0;
            cnt_nxt     = '0;
            state_nxt   = SLOT_LOW;
            // Move to the next BRAM address right away so it has a whole byte time to settle.
            if ((phase == PH_DATA) && rw && (data_idx != {1'b0, dlen}))
               data_idx_nxt = data_idx + 5'd1;
         end
         SLOT_LOW: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt >= low_c - 16'd1)
               state_nxt = SLOT_REL;
         end
         SLOT_REL: begin
            cnt_nxt = cnt + 16'd1;
            if (is_read && (cnt == RDS_C))
               rbit_nxt = bus.ow_in;
            if (cnt >= SLOT_C - 16'd1) begin
               cnt_nxt = '0;
               sr_nxt  = is_read ? {rbit, sr[7:1]} : {1'b0, sr[7:1]};
               if (bit_cnt == 3'd7) begin
                  state_nxt = NEXT;
               end else begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  state_nxt   = SLOT_LOW;
               end
            end
         end
         NEXT: begin
            if (is_read) begin
               rx_we_nxt   = 1'b1;
               rx_data_nxt = sr;
               rx_addr_nxt = byte_idx;
            end
            state_nxt    = LOAD;
            byte_idx_nxt = '0;
            case (phase)
               PH_ROM: begin
                  if (rc == 3'd0)      phase_nxt = PH_FUNC;
                  else if (rc == 3'd2) phase_nxt = PH_UID;
                  else                 last_byte = 1'b1;
               end
               PH_UID: begin
                  if (byte_idx == 5'd6) phase_nxt = PH_CRC;
                  else                  byte_idx_nxt = byte_idx + 5'd1;
               end
               PH_CRC:  phase_nxt = PH_FUNC;
               PH_FUNC: phase_nxt = PH_DATA;
               default: begin
                  if (byte_idx == {1'b0, dlen}) last_byte = 1'b1;
                  else                          byte_idx_nxt = byte_idx + 5'd1;
               end
            endcase
            if (last_byte) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
`ifdef OW_STRONG_PULLUP_EN
               if (spu_wanted) begin
                  state_nxt = SPU;
                  busy_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end
`endif
            end
         end
         SPU: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt >= SPU_C - 16'd1) begin
               cnt_nxt   = '0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      drive_nxt = (state_nxt == RST_LOW) || (state_nxt == SLOT_LOW);
`ifdef OW_STRONG_PULLUP_EN
      spu_nxt = (state_nxt == SPU);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= PH_ROM;
         cnt      <= '0;
         byte_idx <= '0;
         data_idx <= '0;
         bit_cnt  <= '0;
         sr       <= '0;
         rbit     <= 1'b0;
         rc       <= '0;
         rom      <= '0;
         fun      <= '0;
         dlen     <= '0;
         rw       <= 1'b0;
         uid      <= '0;
         crc      <= '0;
         rx_data  <= '0;
         rx_addr  <= '0;
         rx_we    <= 1'b0;
         drive    <= 1'b0;
         busy     <= 1'b0;
         perr     <= 1'b0;
`ifdef OW_STRONG_PULLUP_EN
         spu      <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         phase    <= phase_nxt;
         cnt      <= cnt_nxt;
         byte_idx <= byte_idx_nxt;
         data_idx <= data_idx_nxt;
         bit_cnt  <= bit_cnt_nxt;
         sr       <= sr_nxt;
         rbit     <= rbit_nxt;
         rc       <= rc_nxt;
         rom      <= rom_nxt;
         fun      <= fun_nxt;
         dlen     <= dlen_nxt;
         rw       <= rw_nxt;
         uid      <= uid_nxt;
         crc      <= crc_nxt;
         rx_data  <= rx_data_nxt;
         rx_addr  <= rx_addr_nxt;
         rx_we    <= rx_we_nxt;
         drive    <= drive_nxt;
         busy     <= busy_nxt;
         perr     <= perr_nxt;
`ifdef OW_STRONG_PULLUP_EN
         spu      <= spu_nxt;
`endif
      end
   end

   assign bus.bram_raddr   = data_idx;
   assign bus.rx_data      = rx_data;
   assign bus.rx_addr      = rx_addr;
   assign bus.rx_we        = rx_we;
   assign bus.ow_drive_low = drive;
   assign bus.ow_busy      = busy;
   assign bus.presence_err = perr;
endmodule

// File: tb/tb_one_wire_bus_master.sv
// Scoreboard bench for one_wire_bus_master: line low-pulse widths, rx bytes and (optionally) ow_spu holds.
module tb_one_wire_bus_master;
   localparam int CPU    = 2;
   localparam int PER    = 10;
   localparam int W_RST  = 480 * CPU;
   localparam int W_ONE  = 6 * CPU;
   localparam int W_ZERO = 60 * CPU;

   typedef struct {
      logic [7:0] d;
      logic [4:0] a;
   } rx_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   one_wire_bus_master_if bus();

   one_wire_bus_master #(.CLKS_PER_US(CPU)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_pulse[$];
   rx_t         exp_rx[$];
   int          exp_spu[$];
   bit          rd_bits[$];
   int          rd_skip  = 1000;
   int          pulse_cnt = 0;
   bit          slave_present = 1'b1;
   logic        pres_low = 1'b0;
   logic        bit_low  = 1'b0;
   logic [7:0]  mem [0:31];
   logic [55:0] uid_val = 56'h77_66_55_44_33_22_28;
   logic [7:0]  crc_val = 8'h9E;
   time         t_mon;
   time         t_pres;
   int          spu_len = 0;

   // Open-drain line: anyone pulling low wins.
   assign bus.ow_in = ~(bus.ow_drive_low | pres_low | bit_low);

   always @(posedge clk) bus.bram_rdata <= mem[bus.bram_raddr];

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++)
         exp_pulse.push_back(b[i] ? W_ONE : W_ZERO);
   endtask

   // Queue every expected line pulse / spu hold, then issue the one-cycle write pulse.
   task automatic apply_stimulus(input logic [2:0] rc, input logic [7:0] rom, input logic [7:0] fun,
                                 input logic [3:0] dlen, input logic rw);
      logic [7:0] ub;
      pulse_cnt = 0;
      exp_pulse.push_back(W_RST);
      push_byte(rom);
      if (rc == 3'd0 || rc == 3'd2) begin
         if (rc == 3'd2) begin
            for (int i = 0; i < 7; i++) begin
               ub = uid_val[i*8 +: 8];
               push_byte(ub);
            end
            push_byte(crc_val);
         end
         push_byte(fun);
         for (int i = 0; i <= int'(dlen); i++) begin
            if (rw) push_byte(mem[i]);
            else for (int j = 0; j < 8; j++) exp_pulse.push_back(W_ONE);
         end
      end
`ifdef OW_STRONG_PULLUP_EN
      if (rw || !(rc == 3'd0 || rc == 3'd2)) exp_spu.push_back(10 * CPU);
`endif
      bus.read_command = rc;
      bus.ROM_command  = rom;
      bus.Fun_cmd      = fun;
      bus.data_length  = dlen;
      bus.read_write   = rw;
      bus.UID_Data     = uid_val;
      bus.uid_crc      = crc_val;
      bus.write        = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
      check_output("ow_busy after start", bus.ow_busy, 1);
      check_output("presence_err cleared on start", bus.presence_err, 0);
   endtask

   task automatic wait_idle(input int limit, input string name);
      bit done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         @(negedge clk);
         if (bus.ow_busy === 1'b0) done = 1'b1;
      end
      check_output(name, bus.ow_busy, 0);
   endtask

   task automatic finish_checks(input logic perr, input logic [4:0] raddr);
      repeat (2) @(negedge clk);
      check_output("presence_err", bus.presence_err, perr);
      check_output("bram_raddr", bus.bram_raddr, raddr);
      check_output("pulses pending", exp_pulse.size(), 0);
      check_output("rx pending", exp_rx.size(), 0);
      check_output("ow_drive_low idle", bus.ow_drive_low, 0);
`ifdef OW_STRONG_PULLUP_EN
      check_output("spu pending", exp_spu.size(), 0);
`endif
   endtask

   initial begin : pulse_monitor
      int width;
      forever begin
         @(posedge bus.ow_drive_low);
         t_mon = $time;
         @(negedge bus.ow_drive_low);
         width = int'(($time - t_mon) / PER);
         if (exp_pulse.size() == 0) check_output("unexpected low pulse", width, 0);
         else check_output("low pulse width", width, exp_pulse.pop_front());
      end
   end

   initial begin : rx_monitor
      rx_t r;
      forever begin
         @(negedge clk);
         if (bus.rx_we === 1'b1) begin
            if (exp_rx.size() == 0) check_output("unexpected rx_we", 1, 0);
            else begin
               r = exp_rx.pop_front();
               check_output("rx_data", bus.rx_data, r.d);
               check_output("rx_addr", bus.rx_addr, r.a);
            end
         end
      end
   end

`ifdef OW_STRONG_PULLUP_EN
   initial begin : spu_monitor
      forever begin
         @(negedge clk);
         if (bus.ow_spu === 1'b1) begin
            spu_len++;
            if (spu_len == 1) check_output("ow_busy during spu", bus.ow_busy, 1);
         end else if (spu_len != 0) begin
            if (exp_spu.size() == 0) check_output("unexpected ow_spu", spu_len, 0);
            else check_output("ow_spu length", spu_len, exp_spu.pop_front());
            check_output("ow_busy falls with ow_spu", bus.ow_busy, 0);
            spu_len = 0;
         end
      end
   end
`endif

   // Slave presence pulse after every full-length reset low.
   initial begin : slave_presence
      forever begin
         @(posedge bus.ow_drive_low);
         t_pres = $time;
         @(negedge bus.ow_drive_low);
         if ((($time - t_pres) / PER) >= 900 && slave_present) begin
            repeat (20) @(posedge clk);
            pres_low = 1'b1;
            repeat (280) @(posedge clk);
            pres_low = 1'b0;
         end
      end
   end

   // Slave read responses: a 0 bit holds the line low past the master's sample point.
   initial begin : slave_bits
      bit b;
      forever begin
         @(posedge bus.ow_drive_low);
         if (pulse_cnt >= rd_skip && rd_bits.size() > 0) begin
            b = rd_bits.pop_front();
            if (!b) begin
               bit_low = 1'b1;
               repeat (60) @(posedge clk);
               bit_low = 1'b0;
            end
         end
         pulse_cnt++;
      end
   end

   initial begin : stimulus
      logic [7:0] rb [3];
      rx_t        r;
      logic       prev;
      int         rises;
      for (int i = 0; i < 32; i++) mem[i] = 8'(i * 17 + 3);
      mem[0] = 8'hA5;
      mem[1] = 8'h3C;
      bus.write = 1'b0;
      bus.read_command = '0;
      bus.ROM_command = '0;
      bus.Fun_cmd = '0;
      bus.data_length = '0;
      bus.read_write = 1'b0;
      bus.UID_Data = '0;
      bus.uid_crc = '0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_output("reset ow_drive_low", bus.ow_drive_low, 0);
      check_output("reset ow_busy", bus.ow_busy, 0);
      check_output("reset rx_we", bus.rx_we, 0);
      check_output("reset presence_err", bus.presence_err, 0);
      check_output("reset bram_raddr", bus.bram_raddr, 0);
      check_output("reset rx_data", bus.rx_data, 0);
      check_output("reset rx_addr", bus.rx_addr, 0);
`ifdef OW_STRONG_PULLUP_EN
      check_output("reset ow_spu", bus.ow_spu, 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] ROM-only 0xCC, slave present");
      apply_stimulus(3'd1, 8'hCC, 8'h00, 4'd0, 1'b0);
      wait_idle(5000, "t1 ow_busy falls");
      finish_checks(1'b0, 5'd0);

      $display("[TB] ROM-only 0xCC, no slave");
      slave_present = 1'b0;
      apply_stimulus(3'd1, 8'hCC, 8'h00, 4'd0, 1'b0);
      wait_idle(5000, "t2 ow_busy falls");
      finish_checks(1'b1, 5'd0);
      slave_present = 1'b1;

      $display("[TB] ROM,UID,CRC,FUNC + 2 BRAM bytes");
      apply_stimulus(3'd2, 8'h55, 8'h4E, 4'd1, 1'b1);
      wait_idle(20000, "t3 ow_busy falls");
      finish_checks(1'b0, 5'd1);

      $display("[TB] ROM,FUNC + 3 read bytes");
      rb[0] = 8'h12;
      rb[1] = 8'h34;
      rb[2] = 8'h56;
      rd_skip = 17;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) rd_bits.push_back(rb[k][i]);
         r.d = rb[k];
         r.a = 5'(k);
         exp_rx.push_back(r);
      end
      apply_stimulus(3'd0, 8'h33, 8'hBE, 4'd2, 1'b0);
      wait_idle(10000, "t4 ow_busy falls");
      finish_checks(1'b0, 5'd0);
      rd_skip = 1000;

      $display("[TB] write pulse while busy is ignored");
      apply_stimulus(3'd1, 8'hF0, 8'h00, 4'd0, 1'b0);
      repeat (100) @(negedge clk);
      bus.ROM_command  = 8'h0F;
      bus.read_command = 3'd0;
      bus.write        = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
      check_output("busy through ignored write", bus.ow_busy, 1);
      wait_idle(5000, "t5a ow_busy falls");
      finish_checks(1'b0, 5'd0);

      $display("[TB] reset in the middle of the first slot");
      apply_stimulus(3'd1, 8'hFF, 8'h00, 4'd0, 1'b0);
      // The transaction is cut short: only the reset pulse and a 5-clock slot fragment appear.
      exp_pulse.delete();
      exp_spu.delete();
      exp_pulse.push_back(W_RST);
      exp_pulse.push_back(5);
      prev  = bus.ow_drive_low;
      rises = 0;
      for (int i = 0; i < 3000 && rises == 0; i++) begin
         @(negedge clk);
         if (!prev && bus.ow_drive_low) rises++;
         prev = bus.ow_drive_low;
      end
      check_output("first slot started", rises, 1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_output("mid-slot reset ow_drive_low", bus.ow_drive_low, 0);
      check_output("mid-slot reset ow_busy", bus.ow_busy, 0);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      finish_checks(1'b0, 5'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
